hood_mode_ctrl: RTL and testbench
=================================

HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100: tick_100hz pulses per second.
REQ-002 Parameter HURRICANE_SEC, default 60: level-3 run time and level-3 exit countdown, in seconds.
REQ-003 Parameter CLEAN_SEC, default 180: self-clean duration, in seconds.
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 tick_100hz  in  1  one-clk enable pulse at 100 Hz.
REQ-007 power_on  in  1  level input from the power/gesture front end.
REQ-008 req_l1, req_l2, req_l3, req_clean, req_stop  in  1 each  one-clk debounced menu pulses.
REQ-009 fan_level  out  2  fan speed: 0 = off, 1..3 = speed level.
REQ-010 mode_state  out  3  current state encoding.
REQ-011 remain_sec  out  8  seconds left in timed states; 0 otherwise.
REQ-012 hurricane_used  out  1  level 3 already taken this power cycle.
REQ-013 clean_active, clean_done  out  1 each  clean in progress; one-clk pulse when clean completes.

Function
REQ-014 States SHALL be OFF=0, STANDBY=1, L1=2, L2=3, L3=4, EXIT_WAIT=5, CLEAN=6.
REQ-015 power_on=0 SHALL force OFF on the next clk from any state, and SHALL clear timers and hurricane_used.
REQ-016 OFF with power_on=1 SHALL go to STANDBY.
REQ-017 Request priority when several pulses coincide SHALL be: stop > l3 > l2 > l1 > clean. Only the winning request acts.
REQ-018 STANDBY: req_l1 -> L1; req_l2 -> L2; req_l3 -> L3 only if hurricane_used=0, otherwise ignored; req_clean -> CLEAN.
REQ-019 L1/L2: req_l1 and req_l2 switch between L1 and L2. req_stop -> STANDBY next clk. req_l3 and req_clean ignored.
REQ-020 L3 entry SHALL set hurricane_used=1 and load remain_sec=HURRICANE_SEC. At expiry the state goes to L2. req_stop -> EXIT_WAIT, which reloads remain_sec=HURRICANE_SEC. All other requests are ignored.
REQ-021 EXIT_WAIT: fan_level stays 3; all requests are ignored; at expiry -> STANDBY.
REQ-022 CLEAN: fan_level=0, clean_active=1, remain_sec loaded with CLEAN_SEC; all requests are ignored. At expiry -> STANDBY with clean_done=1 for one clk.
REQ-023 fan_level SHALL be 0 in OFF/STANDBY/CLEAN, 1 in L1, 2 in L2, and 3 in L3/EXIT_WAIT.
REQ-024 Sub-second counter:
- counts tick_100hz from 0 to TICKS_PER_SEC-1;
- clears on every timed-state entry;
- on wrap, decrements remain_sec.
REQ-025 Expiry SHALL occur on the wrap where remain_sec==1: the state transition and remain_sec=0 happen in the same clk.
REQ-026 remain_sec SHALL never underflow below 0.
REQ-027 Outputs SHALL be registered, giving one clk of latency from request to output.

Reset
REQ-028 reset low SHALL immediately force, regardless of clk:
- state OFF;
- fan_level 0, remain_sec 0;
- hurricane_used 0, clean_active 0, clean_done 0;
- sub-second counter 0.
REQ-029 Deassertion mid-operation SHALL resume from OFF; no state is retained.

Configuration
REQ-030 Macro HOOD_SELF_CLEAN_EN defined: CLEAN state and the clean outputs behave as specified above.
REQ-031 Macro undefined: req_clean is ignored, CLEAN is unreachable, and clean_active and clean_done are tied to 0.

Structure
REQ-032 Package hood_pkg SHALL hold the state encoding constants, the fan level constants and the default second counts.
REQ-033 Sub-module sec_countdown SHALL implement the sub-second counter, the remain_sec load/decrement and an expiry pulse.

Verification (TICKS_PER_SEC=4, HURRICANE_SEC=3, CLEAN_SEC=5)
REQ-034 power_on=1, then req_l2 -> STANDBY, then L2, fan_level=2; then req_stop -> STANDBY, fan_level=0.
REQ-035 req_l3 from STANDBY -> remain_sec 3,2,1,0 every 4 ticks, then L2; a second req_l3 after req_stop is ignored.
REQ-036 In L3, req_stop -> EXIT_WAIT with remain_sec=3 and fan_level=3; after 12 ticks -> STANDBY.
REQ-037 Coincident req_stop and req_l1 in L2 -> STANDBY. Coincident req_l1 and req_l2 in STANDBY -> L2.
REQ-038 req_clean -> CLEAN for 20 ticks, then clean_done high for exactly one clk, then STANDBY. With HOOD_SELF_CLEAN_EN undefined, the state stays STANDBY.
REQ-039 power_on dropped, and separately reset pulsed low mid-L3 -> OFF next clk (reset: immediately); outputs zero and hurricane_used=0.

Source files
------------

// File: rtl/hood_pkg.sv
// Shared constants for the range-hood mode controller: state encoding,
// fan levels, default second counts and small state helpers.
package hood_pkg;

   typedef enum logic [2:0] {
      ST_OFF       = 3'd0,
      ST_STANDBY   = 3'd1,
      ST_L1        = 3'd2,
      ST_L2        = 3'd3,
      ST_L3        = 3'd4,
      ST_EXIT_WAIT = 3'd5,
      ST_CLEAN     = 3'd6
   } state_t;

   localparam logic [1:0] FAN_OFF = 2'd0;
   localparam logic [1:0] FAN_L1  = 2'd1;
   localparam logic [1:0] FAN_L2  = 2'd2;
   localparam logic [1:0] FAN_L3  = 2'd3;

   localparam int DEF_TICKS_PER_SEC = 100;
   localparam int DEF_HURRICANE_SEC = 60;
   localparam int DEF_CLEAN_SEC     = 180;

   function automatic logic [1:0] fan_of(state_t s);
      case (s)
         ST_L1:                fan_of = FAN_L1;
         ST_L2:                fan_of = FAN_L2;
         ST_L3, ST_EXIT_WAIT:  fan_of = FAN_L3;
         default:              fan_of = FAN_OFF;
      endcase
   endfunction

   function automatic logic is_timed(state_t s);
      is_timed = (s == ST_L3) || (s == ST_EXIT_WAIT) || (s == ST_CLEAN);
   endfunction

endpackage

// File: rtl/hood_mode_ctrl_if.sv
// Front-end pulses/levels into the hood controller and its status outputs.
interface hood_mode_ctrl_if;
   logic       tick_100hz;
   logic       power_on;
   logic       req_l1;
   logic       req_l2;
   logic       req_l3;
   logic       req_clean;
   logic       req_stop;
   logic [1:0] fan_level;
   logic [2:0] mode_state;
   logic [7:0] remain_sec;
   logic       hurricane_used;
   logic       clean_active;
   logic       clean_done;

   modport master (
      output tick_100hz, power_on, req_l1, req_l2, req_l3, req_clean, req_stop,
      input  fan_level, mode_state, remain_sec, hurricane_used, clean_active, clean_done
   );

   modport slave (
      input  tick_100hz, power_on, req_l1, req_l2, req_l3, req_clean, req_stop,
      output fan_level, mode_state, remain_sec, hurricane_used, clean_active, clean_done
   );
endinterface

// File: rtl/hood_mode_ctrl_sec_countdown.sv
// Seconds countdown: sub-second tick counter, remain_sec load/decrement and
// a combinational expiry flag for the wrap that takes remain_sec from 1 to 0.
module sec_countdown #(
   parameter int TICKS_PER_SEC = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       idle,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [7:0] remain,
   output logic       expire
);

   localparam int SW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [SW-1:0] SUB_LAST = SW'(TICKS_PER_SEC - 1);

   logic [SW-1:0] sub;
   logic          wrap;

   assign wrap   = tick && (sub == SUB_LAST);
   assign expire = wrap && (remain == 8'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sub    <= '0;
         remain <= 8'd0;
      end else if (idle) begin
         sub    <= '0;
         remain <= 8'd0;
      end else if (load) begin
         sub    <= '0;
         remain <= load_val;
      end else if (wrap) begin
         sub <= '0;
         if (remain != 8'd0)
            remain <= remain - 8'd1;
      end else if (tick) begin
         sub <= sub + SW'(1);
      end
   end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood fan mode controller. Self-clean mode is built in only when
// HOOD_SELF_CLEAN_EN is defined; otherwise req_clean is ignored.
//
// state        | meaning
// OFF          | power_on low, everything idle
// STANDBY      | powered, fan off
// L1 / L2      | manual fan speed 1 / 2
// L3           | hurricane speed, timed, once per power cycle
// EXIT_WAIT    | speed 3 run-down after stop from L3, timed
// CLEAN        | self-clean, fan off, timed
module hood_mode_ctrl
   import hood_pkg::*;
#(
   parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
   parameter int HURRICANE_SEC = DEF_HURRICANE_SEC,
   parameter int CLEAN_SEC     = DEF_CLEAN_SEC
) (
   input logic            clk,
   input logic            reset,
   hood_mode_ctrl_if.slave bus
);

   state_t     state;
   state_t     nxt;
   logic [1:0] fan_level;
   logic       hurricane_used;
   logic       expire;
   logic       load;
   logic       idle;
   logic [7:0] load_val;
   logic [7:0] remain;

   // Exactly one request wins per clk; a losing or ignored request has no effect.
   always_comb begin
      nxt = state;
      if (!bus.power_on) begin
         nxt = ST_OFF;
      end else begin
         case (state)
            ST_OFF:
               nxt = ST_STANDBY;
            ST_STANDBY: begin
               if (bus.req_stop)
                  nxt = ST_STANDBY;
               else if (bus.req_l3)
                  nxt = hurricane_used ? ST_STANDBY : ST_L3;
               else if (bus.req_l2)
                  nxt = ST_L2;
               else if (bus.req_l1)
                  nxt = ST_L1;
`ifdef HOOD_SELF_CLEAN_EN
               else if (bus.req_clean)
                  nxt = ST_CLEAN;
`endif
            end
            ST_L1, ST_L2: begin
               if (bus.req_stop)
                  nxt = ST_STANDBY;
               else if (bus.req_l3)
                  nxt = state;
               else if (bus.req_l2)
                  nxt = ST_L2;
               else if (bus.req_l1)
                  nxt = ST_L1;
            end
            ST_L3: begin
               if (bus.req_stop)
                  nxt = ST_EXIT_WAIT;
               else if (expire)
                  nxt = ST_L2;
            end
            ST_EXIT_WAIT, ST_CLEAN: begin
               if (expire)
                  nxt = ST_STANDBY;
            end
            default:
               nxt = ST_OFF;
         endcase
      end
   end

   always_comb begin
      load_val = 8'd0;
      case (nxt)
         ST_L3, ST_EXIT_WAIT: load_val = 8'(HURRICANE_SEC);
         ST_CLEAN:            load_val = 8'(CLEAN_SEC);
         default:             load_val = 8'd0;
      endcase
   end

   // Any change into a timed state (including L3 -> EXIT_WAIT) restarts the countdown.
   assign load = is_timed(nxt) && (nxt != state);
   assign idle = !is_timed(nxt);

   sec_countdown #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_sec_countdown (
      .clk      (clk),
      .reset    (reset),
      .tick     (bus.tick_100hz),
      .idle     (idle),
      .load     (load),
      .load_val (load_val),
      .remain   (remain),
      .expire   (expire)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_OFF;
         fan_level      <= FAN_OFF;
         hurricane_used <= 1'b0;
      end else begin
         state     <= nxt;
         fan_level <= fan_of(nxt);
         if (!bus.power_on)
            hurricane_used <= 1'b0;
         else if (nxt == ST_L3)
            hurricane_used <= 1'b1;
      end
   end

`ifdef HOOD_SELF_CLEAN_EN
   logic clean_active;
   logic clean_done;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clean_active <= 1'b0;
         clean_done   <= 1'b0;
      end else begin
         clean_active <= (nxt == ST_CLEAN);
         clean_done   <= (state == ST_CLEAN) && (nxt == ST_STANDBY);
      end
   end

   assign bus.clean_active = clean_active;
   assign bus.clean_done   = clean_done;
`else
   logic unused_req_clean;
   assign unused_req_clean = bus.req_clean;
   assign bus.clean_active = 1'b0;
   assign bus.clean_done   = 1'b0;
`endif

   assign bus.fan_level      = fan_level;
   assign bus.mode_state     = state;
   assign bus.remain_sec     = remain;
   assign bus.hurricane_used = hurricane_used;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed bench for hood_mode_ctrl with TICKS_PER_SEC=4, HURRICANE_SEC=3,
// CLEAN_SEC=5; clean expectations follow HOOD_SELF_CLEAN_EN.
module tb_hood_mode_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   hood_mode_ctrl_if bus ();

   hood_mode_ctrl #(
      .TICKS_PER_SEC (4),
      .HURRICANE_SEC (3),
      .CLEAN_SEC     (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic l1, input logic l2, input logic l3,
                        input logic cl, input logic st);
      bus.req_l1    = l1;
      bus.req_l2    = l2;
      bus.req_l3    = l3;
      bus.req_clean = cl;
      bus.req_stop  = st;
      step();
      bus.req_l1    = 1'b0;
      bus.req_l2    = 1'b0;
      bus.req_l3    = 1'b0;
      bus.req_clean = 1'b0;
      bus.req_stop  = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_100hz = 1'b1;
         step();
      end
      bus.tick_100hz = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset          = 1'b0;
      bus.tick_100hz = 1'b0;
      bus.power_on   = 1'b0;
      bus.req_l1     = 1'b0;
      bus.req_l2     = 1'b0;
      bus.req_l3     = 1'b0;
      bus.req_clean  = 1'b0;
      bus.req_stop   = 1'b0;
      step();
      step();
      chk("rst_state", 8'(bus.mode_state), 8'd0);
      chk("rst_fan", 8'(bus.fan_level), 8'd0);
      chk("rst_remain", bus.remain_sec, 8'd0);
      chk("rst_used", 8'(bus.hurricane_used), 8'd0);

      reset = 1'b1;
      step();
      chk("off_no_power", 8'(bus.mode_state), 8'd0);
      bus.power_on = 1'b1;
      step();
      chk("standby", 8'(bus.mode_state), 8'd1);

      pulse(0, 1, 0, 0, 0);
      chk("l2_state", 8'(bus.mode_state), 8'd3);
      chk("l2_fan", 8'(bus.fan_level), 8'd2);
      pulse(0, 0, 0, 0, 1);
      chk("stop_state", 8'(bus.mode_state), 8'd1);
      chk("stop_fan", 8'(bus.fan_level), 8'd0);

      pulse(0, 0, 1, 0, 0);
      chk("l3_state", 8'(bus.mode_state), 8'd4);
      chk("l3_fan", 8'(bus.fan_level), 8'd3);
      chk("l3_remain", bus.remain_sec, 8'd3);
      chk("l3_used", 8'(bus.hurricane_used), 8'd1);
      ticks(4);
      chk("l3_rem2", bus.remain_sec, 8'd2);
      ticks(4);
      chk("l3_rem1", bus.remain_sec, 8'd1);
      ticks(3);
      chk("l3_pre_exp_state", 8'(bus.mode_state), 8'd4);
      chk("l3_pre_exp_rem", bus.remain_sec, 8'd1);
      ticks(1);
      chk("l3_exp_state", 8'(bus.mode_state), 8'd3);
      chk("l3_exp_rem", bus.remain_sec, 8'd0);
      chk("l3_exp_fan", 8'(bus.fan_level), 8'd2);
      ticks(8);
      chk("l2_rem_stays0", bus.remain_sec, 8'd0);
      pulse(0, 0, 0, 0, 1);
      pulse(0, 0, 1, 0, 0);
      chk("l3_once_state", 8'(bus.mode_state), 8'd1);
      chk("l3_once_fan", 8'(bus.fan_level), 8'd0);

      bus.power_on = 1'b0;
      step();
      chk("poff_state", 8'(bus.mode_state), 8'd0);
      chk("poff_used", 8'(bus.hurricane_used), 8'd0);
      bus.power_on = 1'b1;
      step();
      pulse(0, 0, 1, 0, 0);
      chk("l3_again", 8'(bus.mode_state), 8'd4);
      ticks(5);
      chk("l3_rem_before_stop", bus.remain_sec, 8'd2);
      pulse(0, 0, 0, 0, 1);
      chk("exit_state", 8'(bus.mode_state), 8'd5);
      chk("exit_remain", bus.remain_sec, 8'd3);
      chk("exit_fan", 8'(bus.fan_level), 8'd3);
      pulse(1, 1, 1, 1, 1);
      chk("exit_ignores", 8'(bus.mode_state), 8'd5);
      ticks(11);
      chk("exit_pre_state", 8'(bus.mode_state), 8'd5);
      chk("exit_pre_rem", bus.remain_sec, 8'd1);
      ticks(1);
      chk("exit_done_state", 8'(bus.mode_state), 8'd1);
      chk("exit_done_fan", 8'(bus.fan_level), 8'd0);
      chk("exit_done_rem", bus.remain_sec, 8'd0);

      pulse(0, 1, 0, 0, 0);
      pulse(1, 0, 0, 0, 1);
      chk("stop_beats_l1", 8'(bus.mode_state), 8'd1);
      pulse(1, 1, 0, 0, 0);
      chk("l2_beats_l1", 8'(bus.mode_state), 8'd3);
      pulse(1, 0, 0, 0, 0);
      chk("l2_to_l1_state", 8'(bus.mode_state), 8'd2);
      chk("l2_to_l1_fan", 8'(bus.fan_level), 8'd1);
      pulse(0, 0, 0, 1, 0);
      chk("l1_ignores_clean", 8'(bus.mode_state), 8'd2);
      pulse(0, 0, 0, 0, 1);
      pulse(1, 0, 0, 1, 0);
      chk("l1_beats_clean", 8'(bus.mode_state), 8'd2);
      pulse(0, 0, 0, 0, 1);

      pulse(0, 0, 0, 1, 0);
`ifdef HOOD_SELF_CLEAN_EN
      chk("clean_state", 8'(bus.mode_state), 8'd6);
      chk("clean_fan", 8'(bus.fan_level), 8'd0);
      chk("clean_active", 8'(bus.clean_active), 8'd1);
      chk("clean_remain", bus.remain_sec, 8'd5);
      ticks(19);
      chk("clean_pre_state", 8'(bus.mode_state), 8'd6);
      chk("clean_pre_done", 8'(bus.clean_done), 8'd0);
      ticks(1);
      chk("clean_end_state", 8'(bus.mode_state), 8'd1);
      chk("clean_end_done", 8'(bus.clean_done), 8'd1);
      chk("clean_end_active", 8'(bus.clean_active), 8'd0);
      step();
      chk("clean_done_1clk", 8'(bus.clean_done), 8'd0);
`else
      chk("noclean_state", 8'(bus.mode_state), 8'd1);
      chk("noclean_active", 8'(bus.clean_active), 8'd0);
      ticks(20);
      chk("noclean_done", 8'(bus.clean_done), 8'd0);
      chk("noclean_remain", bus.remain_sec, 8'd0);
`endif

      bus.power_on = 1'b0;
      step();
      bus.power_on = 1'b1;
      step();
      pulse(0, 0, 1, 0, 0);
      ticks(2);
      bus.power_on = 1'b0;
      step();
      chk("poff_l3_state", 8'(bus.mode_state), 8'd0);
      chk("poff_l3_fan", 8'(bus.fan_level), 8'd0);
      chk("poff_l3_rem", bus.remain_sec, 8'd0);
      chk("poff_l3_used", 8'(bus.hurricane_used), 8'd0);
      bus.power_on = 1'b1;
      step();
      pulse(0, 0, 1, 0, 0);
      chk("l3_after_pcycle", 8'(bus.mode_state), 8'd4);
      ticks(2);
      reset = 1'b0;
      #2;
      chk("async_rst_state", 8'(bus.mode_state), 8'd0);
      chk("async_rst_fan", 8'(bus.fan_level), 8'd0);
      chk("async_rst_rem", bus.remain_sec, 8'd0);
      chk("async_rst_used", 8'(bus.hurricane_used), 8'd0);
      reset = 1'b1;
      step();
      chk("resume_standby", 8'(bus.mode_state), 8'd1);
      pulse(0, 0, 1, 0, 0);
      chk("l3_post_rst", bus.remain_sec, 8'd3);
      ticks(3);
      chk("sub_cleared_rem3", bus.remain_sec, 8'd3);
      ticks(1);
      chk("sub_cleared_rem2", bus.remain_sec, 8'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
